// File: rtl/pwm_seq_pkg.sv
// ============================================================================
// Module  : pwm_seq_pkg
// Purpose : Shared grid tables, state encoding and widths for the PWM sweep
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_seq_pkg;

    localparam int N_FREQ = 9;
    localparam int N_DUTY = 10;
    localparam int IDX_W  = 4;
    localparam int FREQ_W = 14;
    localparam int DUTY_W = 8;

    localparam logic [FREQ_W-1:0] FREQ_TAB [N_FREQ] = '{
        14'd100, 14'd200, 14'd500, 14'd700, 14'd1000,
        14'd2000, 14'd5000, 14'd7000, 14'd10000
    };

    localparam logic [DUTY_W-1:0] DUTY_TAB [N_DUTY] = '{
        8'd10, 8'd20, 8'd30, 8'd40, 8'd50,
        8'd60, 8'd70, 8'd80, 8'd90, 8'd100
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } seq_state_t;

    function automatic logic is_last(input logic [IDX_W-1:0] idx, input int n);
        return idx == IDX_W'(n - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_seq_tick.sv
// ============================================================================
// Module  : pwm_seq_tick
// Purpose : 1 ms prescaler with enable and synchronous clear; one-cycle tick
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_seq_tick #(
    parameter int DIV = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int              c_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_W-1:0]  c_LAST = c_W'(DIV - 1);

    logic [c_W-1:0] r_cnt;

    // Count is held at zero whenever disabled so every RUN entry starts a full ms.
    always_ff @(posedge clk) begin
        if (rst || i_clr || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_W'(1);
        end
    end

    assign o_tick = i_en && !i_clr && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/pwm_sweep_seq.sv
// ============================================================================
// Module  : pwm_sweep_seq
// Purpose : Steps freq/duty through the 9x10 grid; updates land on PWM period
//           boundaries (or a timeout) so the generator never glitches.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_sweep_seq
    import pwm_seq_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DWELL_MS    = 500,
    parameter int PEND_TO_CYC = CLK_HZ / 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    input  logic              loop_en,
    input  logic              period_end,
    output logic [FREQ_W-1:0] freq,
    output logic [DUTY_W-1:0] duty,
    output logic [IDX_W-1:0]  freq_idx,
    output logic [IDX_W-1:0]  duty_idx,
    output logic              cfg_upd,
    output logic              wrap,
    output logic              busy
);

    localparam int                 c_MS_DIV     = CLK_HZ / 1000;
    localparam int                 c_DW_W       = $clog2(DWELL_MS + 1);
    localparam logic [c_DW_W-1:0]  c_DWELL_LAST = c_DW_W'(DWELL_MS - 1);
    localparam int                 c_PT_W       = $clog2(PEND_TO_CYC + 1);
    localparam logic [c_PT_W-1:0]  c_PEND_LIM   = c_PT_W'(PEND_TO_CYC);

    seq_state_t        r_state, w_state_nxt;
    logic              r_run, w_run_nxt;
    logic              w_load_next, w_apply;
    logic              w_tick, w_dwell_done, w_pend_trig;
    logic [IDX_W-1:0]  r_nf, r_nd, w_nf, w_nd;
    logic              r_nwrap, w_nwrap;
    logic [c_DW_W-1:0] r_dwell;
    logic [c_PT_W-1:0] r_pend_cnt;

    pwm_seq_tick #(
        .DIV (c_MS_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_state == RUN),
        .i_clr  (w_apply),
        .o_tick (w_tick)
    );

    assign w_dwell_done = w_tick && (r_dwell == c_DWELL_LAST);
    // Timeout fires one cycle after the counter has reached PEND_TO_CYC-1.
    assign w_pend_trig  = period_end || (r_pend_cnt == c_PEND_LIM);

    always_comb begin
        w_nf    = freq_idx;
        w_nd    = duty_idx + IDX_W'(1);
        w_nwrap = 1'b0;
        if (is_last(duty_idx, N_DUTY)) begin
            w_nd = '0;
            if (is_last(freq_idx, N_FREQ)) begin
                w_nf    = '0;
                w_nwrap = 1'b1;
            end else begin
                w_nf = freq_idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_load_next = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            IDLE: begin
                if (stop) begin
                    w_run_nxt = 1'b0;
                end else if (start) begin
                    w_state_nxt = RUN;
                    w_run_nxt   = 1'b1;
                end else if (step) begin
                    w_state_nxt = PEND;
                    w_load_next = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                    w_run_nxt   = 1'b0;
                end else if (start) begin
                    w_state_nxt = RUN;
                end else if (step || w_dwell_done) begin
                    w_state_nxt = PEND;
                    w_load_next = 1'b1;
                end
            end
            PEND: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                    w_run_nxt   = 1'b0;
                end else begin
                    if (start) begin
                        w_run_nxt = 1'b1;
                    end
                    if (w_pend_trig) begin
                        w_apply = 1'b1;
                        if (r_nwrap && !loop_en) begin
                            w_run_nxt = 1'b0;
                        end
                        w_state_nxt = w_run_nxt ? RUN : IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_run_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_run   <= 1'b0;
            busy    <= 1'b0;
            cfg_upd <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            busy    <= (w_state_nxt != IDLE) && w_run_nxt;
            cfg_upd <= w_apply;
            wrap    <= w_apply && r_nwrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || r_state != RUN || w_apply) begin
            r_dwell <= '0;
        end else if (w_dwell_done) begin
            r_dwell <= '0;
        end else if (w_tick) begin
            r_dwell <= r_dwell + c_DW_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || r_state != PEND) begin
            r_pend_cnt <= '0;
        end else if (r_pend_cnt != c_PEND_LIM) begin
            r_pend_cnt <= r_pend_cnt + c_PT_W'(1);
        end
    end

    // Next point is latched on PEND entry and only copied out on apply.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nf     <= '0;
            r_nd     <= '0;
            r_nwrap  <= 1'b0;
            freq_idx <= '0;
            duty_idx <= '0;
            freq     <= FREQ_TAB[0];
            duty     <= DUTY_TAB[0];
        end else begin
            if (w_load_next) begin
                r_nf    <= w_nf;
                r_nd    <= w_nd;
                r_nwrap <= w_nwrap;
            end
            if (w_apply) begin
                freq_idx <= r_nf;
                duty_idx <= r_nd;
                freq     <= FREQ_TAB[r_nf];
                duty     <= DUTY_TAB[r_nd];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pwm_sweep_seq.sv
// ============================================================================
// Module  : tb_pwm_sweep_seq
// Purpose : Randomized scoreboard bench for pwm_sweep_seq
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pwm_sweep_seq;

    localparam int CLK_HZ      = 10_000;
    localparam int DWELL_MS    = 2;
    localparam int PEND_TO_CYC = 50;
    localparam int DWELL_CYC   = DWELL_MS * (CLK_HZ / 1000);
    localparam int N_POINTS    = 90;

    logic        clk = 1'b0;
    logic        rst, start, stop, step, loop_en, period_end;
    logic [13:0] freq;
    logic [7:0]  duty;
    logic [3:0]  freq_idx, duty_idx;
    logic        cfg_upd, wrap, busy;

    typedef struct {
        int f;
        int d;
        int fi;
        int di;
        int w;
        int at;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    int   mp      = 0;
    int   a       = 0;
    int   ftab[9]  = '{100, 200, 500, 700, 1000, 2000, 5000, 7000, 10000};
    int   dtab[10] = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100};

    pwm_sweep_seq #(
        .CLK_HZ      (CLK_HZ),
        .DWELL_MS    (DWELL_MS),
        .PEND_TO_CYC (PEND_TO_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .loop_en    (loop_en),
        .period_end (period_end),
        .freq       (freq),
        .duty       (duty),
        .freq_idx   (freq_idx),
        .duty_idx   (duty_idx),
        .cfg_upd    (cfg_upd),
        .wrap       (wrap),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Model works on the linear grid position p = f*10 + d.
    function automatic void expect_apply(input int at);
        int np;
        np = (mp + 1) % N_POINTS;
        m_e.f  = ftab[np / 10];
        m_e.d  = dtab[np % 10];
        m_e.fi = np / 10;
        m_e.di = np % 10;
        m_e.w  = (mp == N_POINTS - 1) ? 1 : 0;
        m_e.at = at;
        sb.push_back(m_e);
        mp = np;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (cfg_upd) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL cfg_upd_unexpected: got 1, expected 0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("apply_cycle", cyc, e.at);
                    chk("freq", int'(freq), e.f);
                    chk("duty", int'(duty), e.d);
                    chk("freq_idx", int'(freq_idx), e.fi);
                    chk("duty_idx", int'(duty_idx), e.di);
                    chk("wrap", int'(wrap), e.w);
                end
            end else if (wrap) begin
                n_total++;
                $display("FAIL wrap_alone: got 1, expected 0 (cycle %0d)", cyc);
            end
        end
    end

    task automatic go_to(input int c);
        while (cyc < c) @(negedge clk);
        if (cyc != c) begin
            n_total++;
            $display("FAIL schedule: at cycle %0d, expected %0d", cyc, c);
        end
    endtask

    // sel: 0 start, 1 stop, 2 step, 3 period_end, 4 start+stop
    task automatic pulse(input int c, input int sel);
        go_to(c);
        case (sel)
            0: start = 1'b1;
            1: stop = 1'b1;
            2: step = 1'b1;
            3: period_end = 1'b1;
            default: begin
                start = 1'b1;
                stop  = 1'b1;
            end
        endcase
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        step = 1'b0;
        period_end = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_freq"}, int'(freq), 100);
        chk({tag, "_duty"}, int'(duty), 10);
        chk({tag, "_freq_idx"}, int'(freq_idx), 0);
        chk({tag, "_duty_idx"}, int'(duty_idx), 0);
        chk({tag, "_cfg_upd"}, int'(cfg_upd), 0);
        chk({tag, "_wrap"}, int'(wrap), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // Sweep n points while running; a holds the cycle of the last apply.
    task automatic run_points(input int n);
        for (int i = 0; i < n; i++) begin
            int mode, e, d, k;
            mode = $urandom_range(0, 7);
            if (mode == 7) begin
                k = $urandom_range(1, DWELL_CYC - 5);
                pulse(a + k, 2);
                e = a + k + 1;
            end else begin
                e = a + DWELL_CYC;
                if ($urandom_range(0, 3) == 0)
                    pulse(a + $urandom_range(1, DWELL_CYC - 2), 3);
            end
            if (mode == 6) begin
                expect_apply(e + PEND_TO_CYC + 1);
                a = e + PEND_TO_CYC + 1;
                go_to(a);
            end else begin
                d = $urandom_range(0, 8);
                expect_apply(e + d + 1);
                pulse(e + d, 3);
                a = e + d + 1;
            end
        end
    endtask

    initial begin
        int s, e;
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        step = 1'b0;
        loop_en = 1'b1;
        period_end = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_vals("reset");

        // First point via dwell, boundary 3 cycles into PEND.
        s = cyc + 2;
        pulse(s, 0);
        chk("busy_after_start", int'(busy), 1);
        e = s + 1 + DWELL_CYC;
        expect_apply(e + 4);
        pulse(e + 3, 3);
        a = e + 4;
        chk("first_duty_idx", int'(duty_idx), 1);

        run_points(9);
        chk("pt10_freq", int'(freq), 200);
        chk("pt10_duty", int'(duty), 10);
        chk("pt10_freq_idx", int'(freq_idx), 1);

        run_points(N_POINTS - 10);
        chk("wrap_loop_busy", int'(busy), 1);
        chk("wrap_loop_freq", int'(freq), 100);

        loop_en = 1'b0;
        run_points(N_POINTS);
        chk("wrap_noloop_busy", int'(busy), 0);
        go_to(a + 40);
        chk("wrap_noloop_idle_busy", int'(busy), 0);

        // Timeout apply, then stop while pending.
        s = cyc + 1;
        pulse(s, 0);
        e = s + 1 + DWELL_CYC;
        expect_apply(e + PEND_TO_CYC + 1);
        a = e + PEND_TO_CYC + 1;
        go_to(a);
        e = a + DWELL_CYC;
        pulse(e + 5, 1);
        chk("stop_pend_busy", int'(busy), 0);
        pulse(e + 7, 3);
        go_to(e + 20);
        chk("stop_pend_freq_idx", int'(freq_idx), mp / 10);
        chk("stop_pend_duty_idx", int'(duty_idx), mp % 10);
        chk("stop_pend_duty", int'(duty), dtab[mp % 10]);
        pulse(cyc + 1, 4);
        chk("start_stop_busy", int'(busy), 0);
        go_to(cyc + 40);
        chk("start_stop_idle_busy", int'(busy), 0);

        // Manual step from IDLE; a second step while pending is ignored.
        s = cyc + 1;
        pulse(s, 2);
        pulse(s + 2, 2);
        chk("step_busy", int'(busy), 0);
        expect_apply(s + 5);
        pulse(s + 4, 3);
        go_to(s + 45);
        chk("step_idle_busy", int'(busy), 0);

        // Reset mid-RUN.
        s = cyc + 1;
        pulse(s, 0);
        go_to(s + 8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mp = 0;
        check_reset_vals("mid_run_rst");
        go_to(cyc + 40);
        chk("mid_run_rst_busy", int'(busy), 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/pwm_sweep_seq.md
# pwm_sweep_seq

Automatic sweep controller for the PWM generator: steps the frequency/duty setting through the standard 9-frequency × 10-duty grid on a programmable dwell timer or on manual step pulses. Every setting change is held pending and applied only on a PWM period boundary reported by the generator, so outputs never glitch mid-period. It sits between the key debouncers and the PWM generator, replacing the direct key-to-setting path when sweep mode is enabled.

## Interface
- CLK_HZ, 50_000_000, system clock frequency; sets the 1 ms prescaler (CLK_HZ/1000 cycles).
- DWELL_MS, 500, dwell time per grid point in ms (≥1).
- PEND_TO_CYC, CLK_HZ/50, maximum cycles to wait for a period boundary before forcing the update.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin or resume sweeping.
- stop  in  1  one-cycle pulse: halt sweeping and discard any pending update.
- step  in  1  one-cycle pulse: advance one grid point immediately.
- loop_en  in  1  1 = wrap and continue; 0 = halt after the last point.
- period_end  in  1  one-cycle pulse from the PWM generator at each period boundary.
- freq  out  14  applied frequency in Hz.
- duty  out  8  applied duty in percent.
- freq_idx  out  4  applied frequency index, 0..8.
- duty_idx  out  4  applied duty index, 0..9.
- cfg_upd  out  1  one-cycle pulse on the cycle freq/duty change.
- wrap  out  1  one-cycle pulse when the sequence wraps from (8,9) to (0,0).
- busy  out  1  high while in RUN or PEND with the run flag set.

## Operation
- Grid: FREQ_TAB = 100, 200, 500, 700, 1000, 2000, 5000, 7000, 10000 Hz. DUTY_TAB = 10, 20, …, 100 %.
- Ordering: duty index is the inner loop, frequency index the outer loop. The point after (f,9) is (f+1,0); the point after (8,9) is (0,0).
- States:
  - IDLE: no sweeping.
  - RUN: counting dwell.
  - PEND: next point computed; waiting for a boundary.
- Run flag: set by start, cleared by stop.
- IDLE → RUN on start. IDLE → PEND on step; after apply, returns to IDLE.
- RUN → PEND on dwell expiry or step. RUN → IDLE on stop.
- In PEND, period_end or timeout (PEND_TO_CYC cycles) triggers apply. After apply, go to RUN if the run flag is set, otherwise IDLE.
- PEND → IDLE on stop; the pending point is discarded and the outputs are unchanged.
- Apply: copy next indices to the outputs, perform the table lookup, pulse cfg_upd, and restart the dwell and ms counters.
- Wrap:
  - wrap pulses together with cfg_upd when (0,0) is applied after (8,9).
  - If loop_en=0 at wrap, clear the run flag: the (0,0) point is applied, then the block goes to IDLE.
- Priority on the same cycle: stop > start > step > dwell expiry.
- step is ignored while in PEND.
- start while already RUN has no effect and does not restart dwell.

## Timing
- Reset values:
  - State IDLE, run flag 0.
  - freq=100, duty=10, freq_idx=0, duty_idx=0.
  - cfg_upd=0, wrap=0, busy=0.
  - All counters 0.
- ms tick: one cycle every CLK_HZ/1000 cycles while in RUN; the prescaler is held at 0 outside RUN.
- Dwell expiry: on the DWELL_MS-th tick after entering RUN or after the last apply. PEND is entered on the next cycle.
- Boundary apply: period_end high in PEND at cycle t → outputs new and cfg_upd high at t+1, for exactly one cycle.
- Timeout: the PEND counter reaches PEND_TO_CYC-1 with no period_end → apply on the next cycle, identical to a boundary apply.
- period_end outside PEND is ignored.
- rst mid-PEND or mid-RUN: all state returns to reset values on the next edge; no cfg_upd is issued.
- busy is registered: it rises the cycle after start is accepted and falls the cycle after stop.

## Structure
- Package pwm_seq_pkg holds:
  - N_FREQ=9 and N_DUTY=10.
  - The FREQ_TAB and DUTY_TAB constant arrays.
  - The state enum {IDLE, RUN, PEND}.
  - The index width of 4.
- Sub-module pwm_seq_tick: a 1 ms prescaler with enable and synchronous clear, producing a one-cycle tick.
- Everything else (FSM, dwell counter, timeout counter, index increment, table lookup registers) lives in pwm_sweep_seq.

## Test plan
All scenarios use CLK_HZ=10_000, DWELL_MS=2 and PEND_TO_CYC=50: one tick per 10 cycles, dwell of 20 cycles.
- Reset then start, with period_end pulsed 3 cycles after PEND entry:
  - cfg_upd pulses once, one cycle after period_end.
  - Outputs go to freq=100, duty=20, duty_idx=1.
- Dwell through 10 points with a boundary each time: after the 10th apply, freq=200, duty=10, freq_idx=1.
- Sweep to (8,9) with loop_en=1, then the next apply:
  - freq=100, duty=10.
  - wrap and cfg_upd coincide.
  - busy stays 1.
  - Repeat with loop_en=0: same apply, then IDLE and busy=0.
- PEND with no period_end: cfg_upd fires exactly 51 cycles after PEND entry.
- Stop in PEND: no cfg_upd, outputs unchanged, IDLE. Start and stop in the same cycle: the block stays IDLE.
- step in IDLE then period_end:
  - Exactly one advance, then return to IDLE.
  - A second step while in PEND is ignored (still a single advance).
  - rst asserted mid-RUN gives all reset values on the next cycle.
